// File: rtl/level_controller_pkg.sv
// Shared types and constants for the stacker level controller.
package level_pkg;

  localparam int LEVEL_W   = 4;
  localparam int MAX_LEVEL = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } state_t;

  // Elaboration-time helper for sizing the shared counter width.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/level_controller_if.sv
// Game event inputs and progress outputs of the level controller.
interface level_controller_if;
  import level_pkg::*;

  logic               i_start;
  logic               i_place;
  logic [3:0]         i_overlap_width;
  logic [LEVEL_W-1:0] o_current_level;
  logic               o_level_up;
  logic               o_active;
  logic               o_game_over;
  logic               o_win;
  logic [LEVEL_W-1:0] o_best_level;

  // Game input side (player/datapath): drives events, observes progress.
  modport master (
    output i_start, i_place, i_overlap_width,
    input  o_current_level, o_level_up, o_active, o_game_over, o_win, o_best_level
  );

  // Controller side.
  modport slave (
    input  i_start, i_place, i_overlap_width,
    output o_current_level, o_level_up, o_active, o_game_over, o_win, o_best_level
  );

endinterface

// File: rtl/level_controller_down_timer.sv
// Loadable down-counter that saturates at zero and flags when it is empty.
module down_timer #(
  parameter int W = 4
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_value,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load takes priority; otherwise count down one per cycle and stop at zero.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/level_controller.sv
// Game-progress FSM for the stacker: level advance, win/lose, post-drop
// lockout, end-of-game hold and best result since reset.
module level_controller
  import level_pkg::*;
#(
  parameter int NUM_LEVELS      = MAX_LEVEL,
  parameter int LOCKOUT_CYCLES  = 4,
  parameter int END_HOLD_CYCLES = 8
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  level_controller_if.slave  bus
);

  localparam int CNT_W = $clog2(max2(LOCKOUT_CYCLES, END_HOLD_CYCLES) + 1);
  localparam logic [LEVEL_W-1:0] TOP_LEVEL = LEVEL_W'(NUM_LEVELS);
  localparam logic [LEVEL_W-1:0] FIRST_LVL = LEVEL_W'(1);

  state_t             r_state;
  state_t             w_next_state;
  logic [LEVEL_W-1:0] r_level;
  logic [LEVEL_W-1:0] w_next_level;
  logic [LEVEL_W-1:0] r_best;
  logic [LEVEL_W-1:0] w_cleared;
  logic               r_level_up;
  logic               w_level_up;
  logic               r_active;
  logic               r_game_over;
  logic               r_win;
  logic               w_accept;
  logic               w_restart;
  logic               w_enter_end;
  logic               w_lock_zero;
  logic               w_hold_zero;
  logic               w_lock_load;
  logic [CNT_W-1:0]   w_lock_value;

  // An accepted drop arms the lockout; starting a game clears any leftover.
  assign w_lock_load  = w_accept | w_restart;
  assign w_lock_value = w_accept ? CNT_W'(LOCKOUT_CYCLES) : '0;

  down_timer #(.W(CNT_W)) u_lockout (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_load       (w_lock_load),
    .i_load_value (w_lock_value),
    .o_zero       (w_lock_zero)
  );

  down_timer #(.W(CNT_W)) u_end_hold (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_load       (w_enter_end),
    .i_load_value (CNT_W'(END_HOLD_CYCLES)),
    .o_zero       (w_hold_zero)
  );

  // Next-state and next-level decisions from the current state and events.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    w_next_state = r_state;
    w_next_level = r_level;
    w_level_up   = 1'b0;
    w_accept     = 1'b0;
    w_restart    = 1'b0;
    w_enter_end  = 1'b0;
    w_cleared    = '0;
    case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          w_next_state = PLAY;
          w_next_level = FIRST_LVL;
          w_restart    = 1'b1;
        end
      end
      PLAY: begin
        if (bus.i_place && w_lock_zero) begin
          w_accept = 1'b1;
          if (bus.i_overlap_width == 4'd0) begin
            w_next_state = LOSE;
            w_enter_end  = 1'b1;
            w_cleared    = r_level - FIRST_LVL;
          end else if (r_level >= TOP_LEVEL) begin
            w_next_state = WIN;
            w_enter_end  = 1'b1;
            w_cleared    = TOP_LEVEL;
          end else begin
            w_next_level = r_level + FIRST_LVL;
            w_level_up   = 1'b1;
          end
        end
      end
      WIN, LOSE: begin
        if (bus.i_start && w_hold_zero) begin
          w_next_state = PLAY;
          w_next_level = FIRST_LVL;
          w_restart    = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_level = '0;
      end
    endcase
  end

  // State, registered status flags and best-result tracking.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_level     <= '0;
      r_level_up  <= 1'b0;
      r_active    <= 1'b0;
      r_game_over <= 1'b0;
      r_win       <= 1'b0;
      r_best      <= '0;
    end else begin
      r_state     <= w_next_state;
      r_level     <= w_next_level;
      r_level_up  <= w_level_up;
      r_active    <= (w_next_state == PLAY);
      r_game_over <= (w_next_state == LOSE);
      r_win       <= (w_next_state == WIN);
      if (w_enter_end && (w_cleared > r_best)) begin
        r_best <= w_cleared;
      end
    end
  end

  assign bus.o_current_level = r_level;
  assign bus.o_level_up      = r_level_up;
  assign bus.o_active        = r_active;
  assign bus.o_game_over     = r_game_over;
  assign bus.o_win           = r_win;
  assign bus.o_best_level    = r_best;

endmodule

// File: tb/tb_level_controller.sv
// Self-checking bench for level_controller: directed vector table,
// hand-written reset/corner sequences and a randomized run against a
// timestamp-based reference model.
module tb_level_controller;

  localparam int N    = 3;
  localparam int LOCK = 4;
  localparam int HOLD = 8;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_WIN  = 2;
  localparam int M_LOSE = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  level_controller_if bus();

  level_controller #(
    .NUM_LEVELS      (N),
    .LOCKOUT_CYCLES  (LOCK),
    .END_HOLD_CYCLES (HOLD)
  ) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int lvl, input int up, input int act,
                               input int go, input int w, input int best);
    check({tag, ".level"},     8'(bus.o_current_level), 8'(lvl));
    check({tag, ".level_up"},  8'(bus.o_level_up),      8'(up));
    check({tag, ".active"},    8'(bus.o_active),        8'(act));
    check({tag, ".game_over"}, 8'(bus.o_game_over),     8'(go));
    check({tag, ".win"},       8'(bus.o_win),           8'(w));
    check({tag, ".best"},      8'(bus.o_best_level),    8'(best));
  endtask

  // Reference model: game rules expressed with cycle timestamps rather than
  // counters -- a drop is accepted if more than LOCK cycles have passed since
  // the last accepted drop; a restart needs more than HOLD cycles since the
  // game ended.
  int     m_mode, m_level, m_best, m_up;
  longint cyc, last_acc, end_at;

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_level  = 0;
    m_best   = 0;
    m_up     = 0;
    last_acc = -1000;
    end_at   = -1000;
  endtask

  task automatic model_step(input bit s, input bit p, input int ow);
    cyc++;
    m_up = 0;
    case (m_mode)
      M_IDLE: if (s) begin m_mode = M_PLAY; m_level = 1; last_acc = -1000; end
      M_PLAY: begin
        if (p && (cyc - last_acc > LOCK)) begin
          last_acc = cyc;
          if (ow == 0) begin
            m_mode = M_LOSE; end_at = cyc;
            if (m_level - 1 > m_best) m_best = m_level - 1;
          end else if (m_level == N) begin
            m_mode = M_WIN; end_at = cyc;
            if (N > m_best) m_best = N;
          end else begin
            m_level++; m_up = 1;
          end
        end
      end
      default: if (s && (cyc - end_at > HOLD)) begin
        m_mode = M_PLAY; m_level = 1; last_acc = -1000;
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    check_outputs(tag, m_level, m_up, int'(m_mode == M_PLAY), int'(m_mode == M_LOSE),
                  int'(m_mode == M_WIN), m_best);
  endtask

  // One clock cycle: drive inputs, let the edge sample them, step the model.
  task automatic tick(input bit s, input bit p, input int ow);
    bus.i_start         = s;
    bus.i_place         = p;
    bus.i_overlap_width = 4'(ow);
    @(posedge clk);
    model_step(s, p, ow);
    #1;
    bus.i_start = 1'b0;
    bus.i_place = 1'b0;
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    #1 rst_n = 1'b0;
    #1;
    check_outputs(tag, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs({tag, "_release"}, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit s;
    bit p;
    int ow;
    int lvl, up, act, go, w, best;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit s, input bit p, input int ow, input int lvl, input int up,
                     input int act, input int go, input int w, input int best);
    vec_t v;
    v.s = s; v.p = p; v.ow = ow;
    v.lvl = lvl; v.up = up; v.act = act; v.go = go; v.w = w; v.best = best;
    tbl.push_back(v);
  endtask

  initial begin
    bus.i_start         = 1'b0;
    bus.i_place         = 1'b0;
    bus.i_overlap_width = 4'd0;
    cyc = 0;
    model_reset();

    #1;
    check_outputs("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs("reset_release", 0, 0, 0, 0, 0, 0);

    // Directed game sequence: one row per cycle, expected outputs after the edge.
    add(0, 1, 3, 0, 0, 0, 0, 0, 0);          // place in IDLE ignored
    add(1, 0, 0, 1, 0, 1, 0, 0, 0);          // start -> PLAY level 1
    add(0, 1, 3, 2, 1, 1, 0, 0, 0);          // accepted -> level 2
    for (int i = 0; i < 3; i++) add(0, 0, 0, 2, 0, 1, 0, 0, 0);
    add(0, 1, 3, 2, 0, 1, 0, 0, 0);          // 4 cycles later: still locked
    add(0, 1, 3, 3, 1, 1, 0, 0, 0);          // 5 cycles later: accepted
    for (int i = 0; i < 4; i++) add(0, 0, 0, 3, 0, 1, 0, 0, 0);
    add(0, 1, 3, 3, 0, 0, 0, 1, 3);          // place at top level -> WIN
    for (int i = 0; i < 7; i++) add(0, 0, 0, 3, 0, 0, 0, 1, 3);
    add(1, 0, 0, 3, 0, 0, 0, 1, 3);          // hold not yet empty: ignored
    add(1, 0, 0, 1, 0, 1, 0, 0, 3);          // hold empty: restart
    add(0, 1, 2, 2, 1, 1, 0, 0, 3);
    add(0, 0, 0, 2, 0, 1, 0, 0, 3);
    add(0, 1, 2, 2, 0, 1, 0, 0, 3);          // 2 cycles after: dropped
    add(0, 0, 0, 2, 0, 1, 0, 0, 3);
    add(0, 0, 0, 2, 0, 1, 0, 0, 3);
    add(0, 1, 0, 2, 0, 0, 1, 0, 3);          // miss at level 2 -> LOSE
    for (int i = 0; i < 3; i++) add(0, 0, 0, 2, 0, 0, 1, 0, 3);
    add(1, 0, 0, 2, 0, 0, 1, 0, 3);          // start with hold=5: ignored
    for (int i = 0; i < 4; i++) add(0, 0, 0, 2, 0, 0, 1, 0, 3);
    add(1, 0, 0, 1, 0, 1, 0, 0, 3);          // restart from LOSE
    add(0, 1, 1, 2, 1, 1, 0, 0, 3);
    add(1, 0, 0, 2, 0, 1, 0, 0, 3);          // start in PLAY ignored

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].s, tbl[i].p, tbl[i].ow);
      check_outputs($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].up, tbl[i].act,
                    tbl[i].go, tbl[i].w, tbl[i].best);
    end

    // Reset mid-PLAY at level 2 clears everything, including best_level.
    async_reset("midplay_reset");

    // start and place together in IDLE: place ignored, lockout not armed.
    tick(1, 1, 3);
    check_outputs("start_place_same", 1, 0, 1, 0, 0, 0);
    tick(0, 1, 3);
    check_outputs("first_place", 2, 1, 1, 0, 0, 0);

    // Randomized run against the reference model.
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) async_reset("rand_reset");
      tick($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)));
      check_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
